// File: rtl/rtc_pkg.sv
// Shared limits and 12-hour display conversion for the real-time counter.
// Consumers: rtc_prescaler, rtc_timekeeper (alarm option: RTC_ALARM_EN).
package rtc_pkg;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HR_MAX  = 8'd23;

  // Midnight and noon both show as 12; the afternoon hours fold down by twelve.
  function automatic logic [7:0] hour_display(input logic [7:0] hr24,
                                              input logic       mode_12h);
    if (!mode_12h)       return hr24;
    if (hr24 == 8'd0)    return 8'd12;
    if (hr24 > 8'd12)    return hr24 - 8'd12;
    return hr24;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock by exactly CLK_HZ. While it runs, tick is high in the
// cycle where the count wraps; clear takes precedence and returns the count to zero.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] r_pre;
  logic             w_wrap;

  assign w_wrap = run && !clear && (r_pre == PRE_MAX);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (clear) begin
      r_pre <= '0;
    end else if (run) begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Seconds/minutes/hours/day counter with validated time-set load, 12/24-hour
// display and one-cycle tick strobes. Optional alarm: define RTC_ALARM_EN.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DAY_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mode_12h,
`ifdef RTC_ALARM_EN
  input  logic [7:0]       alarm_hour,
  input  logic [7:0]       alarm_minute,
  input  logic             alarm_arm,
  input  logic             alarm_ack,
  output logic             alarm,
`endif
  // set_en is a single-cycle request with no ready: it is always accepted, and
  // exactly one cycle later set_err reports whether the fields were rejected.
  input  logic             set_en,
  input  logic [7:0]       set_hour,
  input  logic [7:0]       set_minute,
  input  logic [7:0]       set_second,
  output logic             set_err,
  output logic [7:0]       hour,
  output logic [7:0]       minute,
  output logic [7:0]       second,
  output logic             pm,
  output logic [DAY_W-1:0] day,
  output logic             sec_tick,
  output logic             min_tick
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [7:0]       r_hr24, r_minute, r_second;
  logic [DAY_W-1:0] r_day;
  logic             r_set_err, r_sec_tick, r_min_tick;

  logic       w_set_valid, w_load, w_tick;
  logic       w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [7:0] w_nxt_second, w_nxt_minute, w_nxt_hr24;

  assign w_set_valid = (set_hour <= HR_MAX) && (set_minute <= MIN_MAX) &&
                       (set_second <= SEC_MAX);
  assign w_load      = set_en && w_set_valid;

  // Any set request freezes the divider for that edge, so a coincident wrap is dropped.
  rtc_prescaler #(
    .CLK_HZ (CLK_HZ),
    .PRE_W  (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (run && !set_en),
    .clear  (w_load),
    .tick   (w_tick)
  );

  assign w_sec_wrap   = (r_second == SEC_MAX);
  assign w_min_wrap   = w_sec_wrap && (r_minute == MIN_MAX);
  assign w_hr_wrap    = w_min_wrap && (r_hr24 == HR_MAX);
  assign w_nxt_second = w_sec_wrap ? 8'd0 : r_second + 8'd1;
  assign w_nxt_minute = w_min_wrap ? 8'd0 : (w_sec_wrap ? r_minute + 8'd1 : r_minute);
  assign w_nxt_hr24   = w_hr_wrap  ? 8'd0 : (w_min_wrap ? r_hr24 + 8'd1 : r_hr24);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hr24     <= '0;
      r_minute   <= '0;
      r_second   <= '0;
      r_day      <= '0;
      r_set_err  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
    end else begin
      r_set_err  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      if (set_en) begin
        if (w_set_valid) begin
          r_hr24   <= set_hour;
          r_minute <= set_minute;
          r_second <= set_second;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (w_tick) begin
        r_second   <= w_nxt_second;
        r_minute   <= w_nxt_minute;
        r_hr24     <= w_nxt_hr24;
        r_sec_tick <= 1'b1;
        r_min_tick <= w_sec_wrap;
        if (w_hr_wrap) r_day <= r_day + 1'b1;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  // Only a real advance can fire the alarm; loading the alarm time directly does not.
  assign w_alarm_hit = w_tick && !set_en && alarm_arm &&
                       (w_nxt_hr24 == alarm_hour) && (w_nxt_minute == alarm_minute) &&
                       (w_nxt_second == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst)                       r_alarm <= 1'b0;
    else if (alarm_ack || !alarm_arm) r_alarm <= 1'b0;
    else if (w_alarm_hit)           r_alarm <= 1'b1;
  end

  assign alarm = r_alarm;
`endif

  assign hour     = hour_display(r_hr24, mode_12h);
  assign pm       = (r_hr24 > 8'd11);
  assign minute   = r_minute;
  assign second   = r_second;
  assign day      = r_day;
  assign set_err  = r_set_err;
  assign sec_tick = r_sec_tick;
  assign min_tick = r_min_tick;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed and randomized checks of rtc_timekeeper (CLK_HZ=4) against a
// time-of-day reference model; alarm steps are included when RTC_ALARM_EN is defined.
module tb_rtc_timekeeper;

  localparam int CLK_HZ = 4;
  localparam int DAY_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, run, mode_12h, set_en;
  logic [7:0]       set_hour, set_minute, set_second;
  logic [7:0]       alarm_hour, alarm_minute;
  logic             alarm_arm, alarm_ack, alarm;
  logic             set_err, pm, sec_tick, min_tick;
  logic [7:0]       hour, minute, second;
  logic [DAY_W-1:0] day;

  rtc_timekeeper #(.CLK_HZ(CLK_HZ), .DAY_W(DAY_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mode_12h     (mode_12h),
`ifdef RTC_ALARM_EN
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .alarm_arm    (alarm_arm),
    .alarm_ack    (alarm_ack),
    .alarm        (alarm),
`endif
    .set_en       (set_en),
    .set_hour     (set_hour),
    .set_minute   (set_minute),
    .set_second   (set_second),
    .set_err      (set_err),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .pm           (pm),
    .day          (day),
    .sec_tick     (sec_tick),
    .min_tick     (min_tick)
  );

`ifndef RTC_ALARM_EN
  assign alarm = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int n_tick = 0;
  int n_mtick = 0;

  // reference model: time of day as seconds since midnight
  int   m_pre, m_tod, m_day;
  logic m_err, m_st, m_mt, m_alarm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_hour();
    int h;
    h = m_tod / 3600;
    if (!mode_12h) return h;
    if (h == 0)    return 12;
    if (h > 12)    return h - 12;
    return h;
  endfunction

  task automatic model_edge();
    bit advanced;
    advanced = 0;
    if (!rst) begin
      m_pre = 0; m_tod = 0; m_day = 0;
      m_err = 0; m_st = 0; m_mt = 0; m_alarm = 0;
      return;
    end
    m_err = 0; m_st = 0; m_mt = 0;
    if (set_en) begin
      if (set_hour < 24 && set_minute < 60 && set_second < 60) begin
        m_tod = set_hour * 3600 + set_minute * 60 + set_second;
        m_pre = 0;
      end else begin
        m_err = 1;
      end
    end else if (run) begin
      if (m_pre == CLK_HZ - 1) begin
        m_pre = 0;
        m_tod = (m_tod + 1) % 86400;
        if (m_tod == 0) m_day = (m_day + 1) % (1 << DAY_W);
        m_st = 1;
        m_mt = (m_tod % 60 == 0);
        advanced = 1;
      end else begin
        m_pre++;
      end
    end
`ifdef RTC_ALARM_EN
    if (alarm_ack || !alarm_arm) m_alarm = 0;
    else if (advanced && m_tod == alarm_hour * 3600 + alarm_minute * 60) m_alarm = 1;
`endif
  endtask

  task automatic check_all();
    chk("hour",     hour,     exp_hour());
    chk("minute",   minute,   (m_tod / 60) % 60);
    chk("second",   second,   m_tod % 60);
    chk("pm",       pm,       (m_tod >= 12 * 3600));
    chk("day",      day,      m_day);
    chk("set_err",  set_err,  m_err);
    chk("sec_tick", sec_tick, m_st);
    chk("min_tick", min_tick, m_mt);
    chk("alarm",    alarm,    m_alarm);
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (sec_tick === 1'b1) n_tick++;
    if (min_tick === 1'b1) n_mtick++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int h, input int m, input int s);
    set_en = 1'b1; set_hour = 8'(h); set_minute = 8'(m); set_second = 8'(s);
    cycle();
    set_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; mode_12h = 1'b0; set_en = 1'b0;
    set_hour = '0; set_minute = '0; set_second = '0;
    alarm_hour = '0; alarm_minute = '0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    m_pre = 0; m_tod = 0; m_day = 0; m_err = 0; m_st = 0; m_mt = 0; m_alarm = 0;

    // reset state, both display modes
    run_cycles(2);
    chk("rst_hour24", hour, 0);
    mode_12h = 1'b1; #1;
    chk("rst_hour12", hour, 12);
    chk("rst_pm", pm, 0);
    mode_12h = 1'b0;

    // free run: 8 cycles -> two seconds
    rst = 1'b1; run = 1'b1; n_tick = 0; n_mtick = 0;
    run_cycles(8);
    chk("run8_second", second, 2);
    chk("run8_ticks", n_tick, 2);
    chk("run8_mticks", n_mtick, 0);

    // midnight rollover
    load(23, 59, 58);
    n_mtick = 0;
    run_cycles(4);
    chk("roll_s59", second, 59);
    run_cycles(4);
    chk("roll_hour", hour, 0);
    chk("roll_min", minute, 0);
    chk("roll_sec", second, 0);
    chk("roll_day", day, 1);
    chk("roll_mtick", min_tick, 1);
    chk("roll_mticks", n_mtick, 1);

    // rejected loads
    load(24, 0, 0);
    chk("bad_hour_err", set_err, 1);
    chk("bad_hour_keep", hour, 0);
    cycle();
    chk("err_one_cycle", set_err, 0);
    load(0, 60, 0);
    chk("bad_min_err", set_err, 1);

    // load coinciding with prescaler wrap
    load(1, 2, 3);
    run_cycles(3);
    load(10, 20, 30);
    chk("wrap_load_sec", second, 30);
    chk("wrap_no_tick", sec_tick, 0);
    run_cycles(3);
    chk("wrap_wait_sec", second, 30);
    cycle();
    chk("wrap_next_sec", second, 31);
    chk("wrap_next_tick", sec_tick, 1);

    // 12-hour display and stopped clock
    run = 1'b0; mode_12h = 1'b1;
    load(0, 0, 0);
    chk("h12_0", hour, 12);  chk("pm_0", pm, 0);
    load(12, 0, 0);
    chk("h12_12", hour, 12); chk("pm_12", pm, 1);
    load(13, 5, 7);
    chk("h12_13", hour, 1);  chk("pm_13", pm, 1);
    n_tick = 0;
    run_cycles(20);
    chk("stop_sec", second, 7);
    chk("stop_ticks", n_tick, 0);
    mode_12h = 1'b0; #1;
    chk("h24_13", hour, 13);

`ifdef RTC_ALARM_EN
    run = 1'b1; alarm_hour = 8'd7; alarm_minute = 8'd30; alarm_arm = 1'b1;
    load(7, 29, 59);
    run_cycles(4);
    chk("alarm_fire", alarm, 1);
    alarm_ack = 1'b1;
    cycle();
    chk("alarm_ack", alarm, 0);
    alarm_ack = 1'b0;
    load(7, 30, 0);
    run_cycles(6);
    chk("alarm_direct_load", alarm, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      run      = ($urandom_range(0, 9) != 0);
      mode_12h = $urandom_range(0, 1);
      set_en   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) != 0) begin
        set_hour   = 8'($urandom_range(22, 24));
        set_minute = 8'($urandom_range(58, 60));
        set_second = 8'($urandom_range(56, 60));
      end else begin
        set_hour   = 8'($urandom_range(0, 25));
        set_minute = 8'($urandom_range(0, 61));
        set_second = 8'($urandom_range(0, 61));
      end
      alarm_hour   = 8'($urandom_range(22, 23));
      alarm_minute = 8'($urandom_range(58, 59));
      alarm_arm    = ($urandom_range(0, 15) != 0);
      alarm_ack    = ($urandom_range(0, 30) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
